cnt_int_arb: RTL and testbench

- Interrupt arbiter for the multi-channel counter array: collects the six 8-bit and four 32-bit counter interrupt outputs and presents one CPU interrupt with a source vector.
- Edge-detects and latches each source into a pending register, applies a mask, round-robin arbitrates, and holds irq/irq_vec until acknowledged.
- Software access uses the same cs/rw/addr/wdata/rdata register bus as the counter register block, decoded in a separate address window.

---
 rtl/cnt_int_arb.sv | 177 +++++++++++++++++
 tb/tb_cnt_int_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cnt_int_arb.sv
// Interrupt arbiter for the counter array: edge-detected pending latch, mask, round-robin grant held until ack.
// Optional ack timeout is enabled with the CNT_INT_ARB_TIMEOUT_EN macro.
module cnt_int_arb #(
    parameter int N_SRC  = 10,
    parameter int VEC_W  = 4,
    parameter int TO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] int_in,
    input  logic             cs,
    input  logic             rw,
    input  logic [7:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack
);

    localparam logic [7:0] A_PEND  = 8'h00;
    localparam logic [7:0] A_MASK  = 8'h04;
    localparam logic [7:0] A_SWSET = 8'h08;
    localparam logic [7:0] A_STAT  = 8'h0C;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    if (((1 << VEC_W) < N_SRC) || (TO_CYC < 1)) begin : g_param_check
        $error("cnt_int_arb: VEC_W too small for N_SRC or TO_CYC < 1");
    end

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   int_d_q;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [VEC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [VEC_W-1:0]   irq_vec_q, irq_vec_d;

    logic               wr_en, rd_en;
    logic [N_SRC-1:0]   rise, elig, pend_w1c, sw_set, ack_clr;
    logic               stat_to_clr;
    logic               to_set;
    logic               to_flag;
    logic [VEC_W-1:0]   pick;
    logic               unused_wdata;

    assign unused_wdata = ^wdata;

    // Search upward from ptr+1 with wrap; iterating downward leaves the nearest hit in res.
    function automatic logic [VEC_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                 input logic [VEC_W-1:0] ptr);
        logic [(1<<VEC_W)-1:0] req_w;
        logic [VEC_W:0]        idx;
        logic [VEC_W-1:0]      res;
        req_w = (1<<VEC_W)'(req);
        res   = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = {1'b0, ptr} + (VEC_W+1)'(k);
            if (idx >= (VEC_W+1)'(N_SRC)) begin
                idx = idx - (VEC_W+1)'(N_SRC);
            end
            if (req_w[idx[VEC_W-1:0]]) begin
                res = idx[VEC_W-1:0];
            end
        end
        return res;
    endfunction

    assign wr_en       = cs & rw;
    assign rd_en       = cs & ~rw;
    assign rise        = int_in & ~int_d_q;
    assign elig        = pend_q & mask_q;
    assign pick        = rr_pick(elig, rr_ptr_q);
    assign pend_w1c    = (wr_en && addr == A_PEND)  ? wdata[N_SRC-1:0] : '0;
    assign sw_set      = (wr_en && addr == A_SWSET) ? wdata[N_SRC-1:0] : '0;
    assign stat_to_clr = wr_en && (addr == A_STAT) && wdata[30];

`ifdef CNT_INT_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_flag_q, to_flag_d;
    logic            to_expire;

    assign to_expire = (to_cnt_q == TO_W'(TO_CYC - 1));
    assign to_flag   = to_flag_q;
    assign to_flag_d = (to_flag_q & ~stat_to_clr) | to_set;
    assign to_cnt_d  = (state_q == GRANT && state_d == GRANT) ? to_cnt_q + TO_W'(1) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end
`else
    logic to_expire;
    assign to_expire = 1'b0;
    assign to_flag   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        irq_vec_d = irq_vec_q;
        rr_ptr_d  = rr_ptr_q;
        ack_clr   = '0;
        to_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    irq_vec_d = pick;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                // Ack wins over a simultaneous timeout; a timeout leaves PEND set for a later retry.
                if (irq_ack) begin
                    ack_clr  = {{(N_SRC-1){1'b0}}, 1'b1} << irq_vec_q;
                    rr_ptr_d = irq_vec_q;
                    state_d  = IDLE;
                end else if (to_expire) begin
                    to_set   = 1'b1;
                    rr_ptr_d = irq_vec_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Any set source beats a software or ack clear in the same cycle.
    assign pend_d = (pend_q & ~(pend_w1c | ack_clr)) | rise | sw_set;
    assign mask_d = (wr_en && addr == A_MASK) ? wdata[N_SRC-1:0] : mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            int_d_q   <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            rr_ptr_q  <= VEC_W'(N_SRC - 1);
            irq_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            int_d_q   <= int_in;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            rr_ptr_q  <= rr_ptr_d;
            irq_vec_q <= irq_vec_d;
        end
    end

    assign irq     = (state_q == GRANT);
    assign irq_vec = irq_vec_q;

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                A_PEND: rdata[N_SRC-1:0] = pend_q;
                A_MASK: rdata[N_SRC-1:0] = mask_q;
                A_STAT: begin
                    rdata[31]          = (state_q == GRANT);
                    rdata[30]          = to_flag;
                    rdata[VEC_W-1:0]   = irq_vec_q;
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_int_arb.sv
// Directed vector bench for cnt_int_arb: each record drives one cycle and checks irq, irq_vec and rdata before the edge.
module tb_cnt_int_arb;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [9:0]  int_in;
        logic        ack;
        logic        e_irq;
        logic [3:0]  e_vec;
        logic [31:0] e_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  int_in = '0;
    logic        cs = 1'b0;
    logic        rw = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [3:0]  irq_vec;
    logic        irq_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    cnt_int_arb #(.N_SRC(10), .VEC_W(4), .TO_CYC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .int_in  (int_in),
        .cs      (cs),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic c, input logic w, input logic [7:0] a,
                                input logic [31:0] wd, input logic [9:0] ii, input logic k,
                                input logic ei, input logic [3:0] ev, input logic [31:0] er);
        vec_t v;
        v.rst = r; v.cs = c; v.rw = w; v.addr = a; v.wdata = wd; v.int_in = ii; v.ack = k;
        v.e_irq = ei; v.e_vec = ev; v.e_rd = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; cs = v.cs; rw = v.rw; addr = v.addr; wdata = v.wdata;
        int_in = v.int_in; irq_ack = v.ack;
        #1;
        check({tag, " irq"},     {31'd0, irq},     {31'd0, v.e_irq});
        check({tag, " irq_vec"}, {28'd0, irq_vec}, {28'd0, v.e_vec});
        check({tag, " rdata"},   rdata,            v.e_rd);
        $display("%s: rst=%0b cs=%0b rw=%0b addr=0x%02h wdata=0x%0h int_in=0x%03h ack=%0b -> irq=%0b vec=%0d rdata=0x%0h",
                 tag, v.rst, v.cs, v.rw, v.addr, v.wdata, v.int_in, v.ack, irq, irq_vec, rdata);
    endtask

    vec_t tbl[$];

    initial begin
        // basic grant of source 2 after reset
        tbl.push_back(mk(1,0,0,8'h00,32'h0,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h04,32'h0,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h0C,32'h0,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,1,8'h04,32'h3FF,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h04,32'h0,10'h004,0, 0,0,32'h3FF));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,0,32'h004));
        tbl.push_back(mk(0,1,0,8'h0C,32'h0,10'h000,0, 1,2,32'h8000_0002));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,1, 1,2,32'h004));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,2,32'h0));
        // round robin 0,3,7 then 9 before 0
        tbl.push_back(mk(1,0,0,8'h00,32'h0,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,1,8'h04,32'h3FF,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h089,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,0,32'h089));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,1, 1,0,32'h089));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,0,32'h088));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,1, 1,3,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,0, 0,3,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,1, 1,7,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h201,0, 0,7,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,7,32'h201));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,1, 1,9,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,0, 0,9,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,1, 1,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,0,32'h0));
        // masked source pends without irq until enabled
        tbl.push_back(mk(0,1,1,8'h04,32'h0,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h020,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,0,32'h020));
        tbl.push_back(mk(0,1,0,8'h0C,32'h0,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,1,8'h04,32'h020,10'h000,0, 0,0,32'h0));
        tbl.push_back(mk(0,1,0,8'h04,32'h0,10'h000,0, 0,0,32'h020));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,1, 1,5,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,0, 0,5,32'h0));
        // committed grant of 4 survives W1C and mask; rise in ack cycle wins
        tbl.push_back(mk(0,1,1,8'h04,32'h3FF,10'h000,0, 0,5,32'h0));
        tbl.push_back(mk(0,1,1,8'h08,32'h010,10'h000,0, 0,5,32'h0));
        tbl.push_back(mk(0,1,0,8'h08,32'h0,10'h000,0, 0,5,32'h0));
        tbl.push_back(mk(0,1,1,8'h00,32'h010,10'h000,0, 1,4,32'h0));
        tbl.push_back(mk(0,1,1,8'h04,32'h0,10'h000,0, 1,4,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 1,4,32'h0));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h010,1, 1,4,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,4,32'h010));
        tbl.push_back(mk(0,1,0,8'h0C,32'h0,10'h000,0, 0,4,32'h4));
        tbl.push_back(mk(0,0,0,8'h00,32'h0,10'h000,1, 0,4,32'h0));
        tbl.push_back(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,4,32'h010));
        tbl.push_back(mk(0,1,0,8'h10,32'h0,10'h000,0, 0,4,32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // level held high sets PEND once; SWSET grant; reset mid-grant
        apply(mk(0,1,1,8'h00,32'h3FF,10'h000,0, 0,4,32'h0), "lvl_clr");
        for (int i = 0; i < 20; i++) begin
            apply(mk(0,1,0,8'h00,32'h0,10'h002,0, 0,4,(i == 0) ? 32'h0 : 32'h002),
                  $sformatf("lvl_hold%0d", i));
        end
        apply(mk(0,1,1,8'h00,32'h002,10'h002,0, 0,4,32'h0), "lvl_w1c");
        apply(mk(0,1,0,8'h00,32'h0,10'h002,0, 0,4,32'h0),   "lvl_no_reset");
        apply(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,4,32'h0),   "lvl_release");
        apply(mk(0,1,1,8'h04,32'h200,10'h000,0, 0,4,32'h0), "sw_mask");
        apply(mk(0,1,1,8'h08,32'h200,10'h000,0, 0,4,32'h0), "sw_set");
        apply(mk(0,0,0,8'h00,32'h0,10'h000,0, 0,4,32'h0),   "sw_wait");
        apply(mk(0,1,0,8'h0C,32'h0,10'h000,0, 1,9,32'h8000_0009), "sw_grant");
        apply(mk(1,0,0,8'h00,32'h0,10'h000,0, 0,0,32'h0),   "rst_mid_grant");
        apply(mk(0,1,0,8'h00,32'h0,10'h000,0, 0,0,32'h0),   "rst_pend");
        apply(mk(0,1,0,8'h04,32'h0,10'h000,0, 0,0,32'h0),   "rst_mask");

`ifdef CNT_INT_ARB_TIMEOUT_EN
        apply(mk(0,1,1,8'h04,32'h3FF,10'h000,0, 0,0,32'h0), "to_mask");
        apply(mk(0,1,1,8'h08,32'h003,10'h000,0, 0,0,32'h0), "to_swset");
        apply(mk(0,0,0,8'h00,32'h0,10'h000,0, 0,0,32'h0),   "to_wait");
        for (int i = 0; i < 8; i++) begin
            apply(mk(0,0,0,8'h00,32'h0,10'h000,0, 1,0,32'h0), $sformatf("to_hold%0d", i));
        end
        apply(mk(0,1,0,8'h0C,32'h0,10'h000,0, 0,0,32'h4000_0000), "to_expired");
        apply(mk(0,1,0,8'h00,32'h0,10'h000,1, 1,1,32'h003),       "to_next_grant");
        apply(mk(0,1,1,8'h0C,32'h4000_0000,10'h000,0, 0,1,32'h0), "to_flag_clr");
        apply(mk(0,1,0,8'h0C,32'h0,10'h000,1, 1,0,32'h8000_0000), "to_retry");
`else
        apply(mk(0,1,1,8'h0C,32'h4000_0000,10'h000,0, 0,0,32'h0), "stat_wr");
        apply(mk(0,1,0,8'h0C,32'h0,10'h000,0, 0,0,32'h0),         "stat_no_to");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
